// File: rtl/mac_sat_canal_if.sv
// Operand and result handshake bundle of the saturating MAC.
// The master modport is the sequencer/summing side; the slave modport is the MAC itself.
interface mac_sat_canal_if #(
    parameter int ancho   = 20,
    parameter int canales = 4
);
    localparam int cw = $clog2(canales);

    logic             in_valid;
    logic             in_ready;
    logic [ancho-1:0] X;
    logic [ancho-1:0] Z;
    logic [cw-1:0]    canal;
    logic             primero;
    logic             ultimo;

    logic [ancho-1:0] Y;
    logic [cw-1:0]    y_canal;
    logic             y_valid;
    logic             y_ready;
    logic             sat_mul;
    logic             sat_acc;
    logic [canales-1:0] sat_pegado;

    modport master (
        output in_valid, X, Z, canal, primero, ultimo, y_ready,
        input  in_ready, Y, y_canal, y_valid, sat_mul, sat_acc, sat_pegado
    );

    modport slave (
        input  in_valid, X, Z, canal, primero, ultimo, y_ready,
        output in_ready, Y, y_canal, y_valid, sat_mul, sat_acc, sat_pegado
    );
endinterface

// File: rtl/mac_sat_canal.sv
// Multi-channel saturating fixed-point MAC: Y appears 4 cycles after an ultimo beat is accepted, 1 beat/cycle.
// A held result (y_valid && !y_ready) freezes every stage, blocks accumulator writes and drops in_ready.
module mac_sat_canal #(
    parameter int ancho     = 20,
    parameter int signo     = 1,
    parameter int magnitud  = 5,
    parameter int precision = 14,
    parameter int canales   = 4,
    parameter int redondeo  = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    mac_sat_canal_if.slave bus
);
    localparam int cw  = $clog2(canales);
    localparam int pw  = 2 * ancho;
    localparam int top = 2 * precision + magnitud;
    localparam logic [ancho-1:0] maxpos = {1'b0, {(ancho-1){1'b1}}};
    localparam logic [ancho-1:0] maxneg = {1'b1, {(ancho-1){1'b0}}};
    localparam logic [pw-1:0]    rnd_k  = (redondeo != 0) ? (pw'(1) << (precision - 1)) : '0;

    if (ancho != signo + magnitud + precision) begin : g_bad_width
        $error("mac_sat_canal: ancho must equal signo+magnitud+precision");
    end

    logic stall;

    // S1: operand capture
    logic                    v1, p1, u1;
    logic signed [ancho-1:0] x1, z1;
    logic [cw-1:0]           c1;

    // S2: product, rounding, saturation
    logic signed [pw-1:0] prod_full;
    logic [pw-1:0]        prod_rnd;
    logic                 prod_zero, prod_ovf, prod_sat;
    logic [ancho-1:0]     prod_q;
    logic                 unused_lsb;
    logic                 v2, p2, u2, sm2;
    logic [ancho-1:0]     prod2;
    logic [cw-1:0]        c2;

    // S3: accumulator read-modify-write
    logic [ancho-1:0]   acc [canales];
    logic [canales-1:0] fm, fa, peg;
    logic [ancho-1:0]   base, acc_new;
    logic [ancho:0]     sum;
    logic               sa, m_new, a_new;
    logic               v3, u3, m3, a3;
    logic [ancho-1:0]   y3;
    logic [cw-1:0]      c3;

    // Output register
    logic             yv, ym, ya;
    logic [ancho-1:0] yq;
    logic [cw-1:0]    yc;

    assign stall        = yv && !bus.y_ready;
    assign bus.in_ready = !stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            p1 <= 1'b0;
            u1 <= 1'b0;
            x1 <= '0;
            z1 <= '0;
            c1 <= '0;
        end else if (!stall) begin
            v1 <= bus.in_valid;
            p1 <= bus.primero;
            u1 <= bus.ultimo;
            x1 <= bus.X;
            z1 <= bus.Z;
            c1 <= bus.canal;
        end
    end

    // Overflow is judged on the rounded product's own upper bits; the clamp direction uses the
    // true operand sign, so a tiny negative product rounded up to zero stays zero.
    always_comb begin
        prod_full = pw'(x1) * pw'(z1);
        prod_rnd  = prod_full + rnd_k;
        prod_zero = (x1 == '0) || (z1 == '0);
        prod_ovf  = !((&prod_rnd[pw-1:top]) || !(|prod_rnd[pw-1:top]));
        prod_q    = {prod_rnd[pw-1], prod_rnd[top-1:precision]};
        prod_sat  = 1'b0;
        if (prod_zero) begin
            prod_q = '0;
        end else if (prod_ovf) begin
            prod_q   = (x1[ancho-1] ^ z1[ancho-1]) ? maxneg : maxpos;
            prod_sat = 1'b1;
        end
    end

    assign unused_lsb = ^prod_rnd[precision-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            p2    <= 1'b0;
            u2    <= 1'b0;
            sm2   <= 1'b0;
            prod2 <= '0;
            c2    <= '0;
        end else if (!stall) begin
            v2    <= v1;
            p2    <= p1;
            u2    <= u1;
            sm2   <= prod_sat;
            prod2 <= prod_q;
            c2    <= c1;
        end
    end

    always_comb begin
        base    = p2 ? '0 : acc[c2];
        sum     = {base[ancho-1], base} + {prod2[ancho-1], prod2};
        sa      = sum[ancho] != sum[ancho-1];
        acc_new = sa ? (sum[ancho] ? maxneg : maxpos) : sum[ancho-1:0];
        m_new   = (!p2 && fm[c2]) || sm2;
        a_new   = (!p2 && fa[c2]) || sa;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < canales; i++) acc[i] <= '0;
            fm  <= '0;
            fa  <= '0;
            peg <= '0;
            v3  <= 1'b0;
            u3  <= 1'b0;
            m3  <= 1'b0;
            a3  <= 1'b0;
            y3  <= '0;
            c3  <= '0;
        end else if (!stall) begin
            v3 <= v2;
            u3 <= u2;
            m3 <= m_new;
            a3 <= a_new;
            y3 <= acc_new;
            c3 <= c2;
            if (v2) begin
                acc[c2] <= acc_new;
                fm[c2]  <= m_new;
                fa[c2]  <= a_new;
                if (sm2 || sa) peg[c2] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            yv <= 1'b0;
            ym <= 1'b0;
            ya <= 1'b0;
            yq <= '0;
            yc <= '0;
        end else if (!stall) begin
            yv <= v3 && u3;
            if (v3 && u3) begin
                yq <= y3;
                yc <= c3;
                ym <= m3;
                ya <= a3;
            end
        end
    end

    assign bus.y_valid    = yv;
    assign bus.Y          = yq;
    assign bus.y_canal    = yc;
    assign bus.sat_mul    = ym;
    assign bus.sat_acc    = ya;
    assign bus.sat_pegado = peg;
endmodule

// File: doc/mac_sat_canal.md
Name: mac_sat_canal

Overview:
- Pipelined, multi-channel, saturating fixed-point multiply-accumulate unit for the equalizer filter bank.
- Successor to the combinational saturating multiplier:
  - adds clocked pipelining, valid/ready flow control and selectable rounding;
  - adds per-channel saturating accumulators, so one instance serves all filter bands time-multiplexed.
- Sits between the coefficient/sample sequencer and the band summing stage.

Parameters:
- ancho, 20, total word width; must equal signo+magnitud+precision.
- signo, 1, sign bits.
- magnitud, 5, integer bits.
- precision, 14, fractional bits.
- canales, 4, number of independent accumulators (power of two, 2..16).
- redondeo, 0, 0 = truncate (floor), 1 = round half up.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit accepts a beat this cycle.
- X  in  ancho  signed operand (sample).
- Z  in  ancho  signed operand (coefficient).
- canal  in  $clog2(canales)  target accumulator.
- primero  in  1  first term: accumulator is loaded with the product instead of adding to it.
- ultimo  in  1  last term: emit the accumulator result.
- Y  out  ancho  signed accumulated result.
- y_canal  out  $clog2(canales)  channel of Y.
- y_valid  out  1  Y is valid.
- y_ready  in  1  downstream accepts Y.
- sat_mul  out  1  a product in this accumulation saturated.
- sat_acc  out  1  an accumulate in this accumulation saturated.
- sat_pegado  out  canales  sticky per-channel saturation flag.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all pipeline valids, y_valid, Y, y_canal, sat_mul, sat_acc and sat_pegado go to 0;
  - accumulators cleared;
  - in_ready = 1 in the first cycle after reset;
  - beats in flight when reset is asserted are discarded.
- Handshake:
  - a beat is accepted when in_valid && in_ready;
  - stall = y_valid && !y_ready;
  - in_ready = !stall;
  - while stalled, every stage holds and no accumulator is written;
  - Y, y_canal, y_valid and the flags are stable until y_ready.
- Pipeline and latency:
  - S1 registers operands and tags;
  - S2 forms the 2*ancho product, rounds and saturates;
  - S3 does the accumulator read-modify-write;
  - output register follows S3;
  - the result of a beat tagged ultimo appears on Y 4 cycles after acceptance, absent stalls;
  - throughput is 1 beat/cycle;
  - back-to-back beats to the same canal are legal; S3 is single-cycle read-modify-write, so no hazard.
- Product scaling:
  - P = X*Z, fraction point at bit 2*precision;
  - redondeo=1: add 2^(precision-1) to P before truncation;
  - truncation drops the low precision bits;
  - ancho-bit result = {P[2*ancho-1], P[2*precision+magnitud-1:precision]}.
- Product saturation:
  - if P[2*ancho-1:2*precision+magnitud] is not all equal to the sign, clamp;
  - positive overflow -> 0x7FFFF, negative overflow -> 0x80000 (for ancho=20);
  - sign is taken from the true product sign, X[msb]^Z[msb];
  - if X==0 or Z==0 the product is exactly 0, with no saturation flag and no rounding effect;
  - any clamp sets sat_mul for that accumulation.
- Accumulate:
  - primero=1: acc = prod; otherwise acc = acc + prod;
  - sum computed in ancho+1 bits;
  - overflow clamps to max positive / max negative and sets sat_acc.
- Flags and output:
  - sat_mul/sat_acc are per-channel and cleared on a primero beat;
  - sat_pegado[c] is set on any saturation in channel c and cleared only by reset;
  - when an ultimo beat reaches S3, the output register loads Y = new acc, y_canal, and the flags ORed with the current beat's flags;
  - primero && ultimo together gives a single-term result equal to the saturated product;
  - accumulators are not cleared after ultimo; the next primero overwrites them.

Test Plan:
- Single term, canal 0, primero=ultimo=1, X=0x06000 (1.5), Z=0x08000 (2.0) -> Y=0x0C000 (3.0) 4 cycles after acceptance; sat_mul=0, sat_acc=0.
- Product saturation: X=0x40000 (16.0), Z=0x01000 (0.25 check) -> Y=0x10000. Then X=0x40000, Z=0x10000 (4.0) -> Y=0x7FFFF, sat_mul=1. Then X=0xC0000 (-16.0), Z=0x10000 -> Y=0x80000, sat_mul=1, sat_pegado[0]=1.
- Rounding, X=0x00001, Z=0x02000 (0.5 LSB product):
  - redondeo=0 -> Y=0x00000;
  - redondeo=1 -> Y=0x00001;
  - with X=0xFFFFF: redondeo=0 -> Y=0xFFFFF, redondeo=1 -> Y=0x00000.
- Interleaved channels:
  - 3 beats each to canal 1 and canal 2, alternating, X=0x04000, Z=0x04000 (1.0);
  - canal 2 Z=0xFC000 (-1.0);
  - results canal 1 Y=0x0C000, canal 2 Y=0xF4000, in issue order.
- Accumulator saturation: canal 3, 3 beats of 12.0 (X=0x30000, Z=0x04000) -> Y=0x7FFFF, sat_acc=1, sat_mul=0.
- Backpressure and reset:
  - hold y_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, Y stable, no beat lost or duplicated once released;
  - assert rst_n=0 for one edge mid-stream -> y_valid=0, sat_pegado=0, and the next single-term beat returns the plain product.
